// File: rtl/activity_accumulator_pkg.sv
// Shared types and constants for the activity accumulator.
package activity_accumulator_pkg;

   typedef enum logic [1:0] {
      ST_OFF,
      ST_RUN,
      ST_DRAIN
   } state_e;

   localparam int unsigned ACT_WIDTH = 16;
   localparam logic [ACT_WIDTH-1:0] ACT_MAX = '1;

endpackage

// File: rtl/activity_accumulator_if.sv
// Spike/control inputs and the activity bus toward the level monitor.
interface activity_accumulator_if
   import activity_accumulator_pkg::*;
#(
   parameter int unsigned WIDTH = ACT_WIDTH
) ();

   logic             enable;
   logic             clear;
   logic             spike_valid;
   logic [7:0]       spike_weight;
   logic [WIDTH-1:0] activity;
   logic             activity_valid;
   logic             saturated;
   logic             idle;

   // Event source / controller side.
   modport master (
      output enable, clear, spike_valid, spike_weight,
      input  activity, activity_valid, saturated, idle
   );

   // Accumulator side.
   modport slave (
      input  enable, clear, spike_valid, spike_weight,
      output activity, activity_valid, saturated, idle
   );

endinterface

// File: rtl/activity_accumulator_decay_ticker.sv
// Decay ticker: free-running period counter that pulses once per DECAY_PERIOD cycles.
module activity_accumulator_decay_ticker #(
   parameter int unsigned DECAY_PERIOD = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic i_run,
   input  logic i_restart,
   output logic o_tick
);

   localparam int unsigned CNT_W = (DECAY_PERIOD > 2) ? $clog2(DECAY_PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECAY_PERIOD - 1);

   logic [CNT_W-1:0] r_cnt;

   // Tick on the last count of the period, only while running.
   always_comb begin
      o_tick = i_run && (r_cnt == CNT_LAST);
   end

   // Count while running; held at zero when stopped, on restart and after each tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_restart || !i_run || o_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/activity_accumulator.sv
// Leaky, saturating integrator of weighted spikes producing the activity word.
module activity_accumulator
   import activity_accumulator_pkg::*;
#(
   parameter int unsigned WIDTH        = ACT_WIDTH,
   parameter int unsigned WEIGHT_SHIFT = 4,
   parameter int unsigned DECAY_SHIFT  = 4,
   parameter int unsigned DECAY_PERIOD = 64
) (
   input logic                  clk,
   input logic                  reset,
   activity_accumulator_if.slave bus
);

   state_e           r_state;
   state_e           w_state_next;
   logic [WIDTH-1:0] r_act;
   logic             r_valid;
   logic             r_sat;

   logic             w_tick;
   logic             w_run;
   logic             w_add;
   logic [WIDTH-1:0] w_step;
   logic [WIDTH-1:0] w_decayed;
   logic [WIDTH:0]   w_inc;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_act_next;

   assign w_run = (r_state != ST_OFF);
   assign w_add = (r_state == ST_RUN) && bus.spike_valid;

   activity_accumulator_decay_ticker #(
      .DECAY_PERIOD(DECAY_PERIOD)
   ) u_ticker (
      .clk      (clk),
      .reset    (reset),
      .i_run    (w_run),
      .i_restart(bus.clear),
      .o_tick   (w_tick)
   );

   // Decay first, then spike add with one carry bit, then saturate; clear overrides all.
   always_comb begin
      w_step = r_act >> DECAY_SHIFT;
      if (w_step == '0 && r_act != '0) begin
         w_step = WIDTH'(1);  // minimum step so the word always reaches zero
      end
      w_decayed = w_tick ? (r_act - w_step) : r_act;
      w_inc     = {{(WIDTH - 7){1'b0}}, bus.spike_weight} << WEIGHT_SHIFT;
      w_sum     = {1'b0, w_decayed} + (w_add ? w_inc : '0);
      if (bus.clear) begin
         w_act_next = '0;
      end else if (w_sum[WIDTH]) begin
         w_act_next = '1;
      end else begin
         w_act_next = w_sum[WIDTH-1:0];
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_OFF;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state; leaving RUN/DRAIN looks at the value being written this cycle.
   always_comb begin
      w_state_next = r_state;
      if (bus.clear) begin
         w_state_next = bus.enable ? ST_RUN : ST_OFF;
      end else begin
         case (r_state)
            ST_OFF: begin
               if (bus.enable) w_state_next = ST_RUN;
            end
            ST_RUN: begin
               if (!bus.enable) w_state_next = (w_act_next == '0) ? ST_OFF : ST_DRAIN;
            end
            ST_DRAIN: begin
               if (bus.enable)             w_state_next = ST_RUN;
               else if (w_act_next == '0) w_state_next = ST_OFF;
            end
            default: w_state_next = ST_OFF;
         endcase
      end
   end

   // Activity word, sample strobe and saturation flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_act   <= '0;
         r_valid <= 1'b0;
         r_sat   <= 1'b0;
      end else begin
         r_act   <= w_act_next;
         r_valid <= w_tick;
         r_sat   <= (w_act_next == '1);
      end
   end

   // Drive the bus outputs.
   always_comb begin
      bus.activity       = r_act;
      bus.activity_valid = r_valid;
      bus.saturated      = r_sat;
      bus.idle           = (r_state == ST_OFF) && (r_act == '0);
   end

endmodule

// File: tb/tb_activity_accumulator.sv
// Randomised and directed bench for activity_accumulator against an arithmetic model.
module tb_activity_accumulator;
   import activity_accumulator_pkg::*;

   localparam int PERIOD = 64;
   localparam int MODE_OFF = 0, MODE_RUN = 1, MODE_DRAIN = 2;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   activity_accumulator_if #(.WIDTH(ACT_WIDTH)) bus ();

   activity_accumulator #(
      .WIDTH       (ACT_WIDTH),
      .WEIGHT_SHIFT(4),
      .DECAY_SHIFT (4),
      .DECAY_PERIOD(PERIOD)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model state, plain integers.
   int m_act   = 0;
   int m_cnt   = 0;
   int m_mode  = MODE_OFF;
   int m_valid = 0;
   int m_sat   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance model and DUT by one clock, then compare every output.
   task automatic cycle();
      int tick, d, a, ncnt, nmode;
      if (reset) begin
         a = 0; ncnt = 0; nmode = MODE_OFF; tick = 0;
      end else begin
         tick = (m_mode != MODE_OFF) && (m_cnt == PERIOD - 1);
         ncnt = (bus.clear || m_mode == MODE_OFF || tick) ? 0 : m_cnt + 1;
         d = m_act / 16;
         if (d == 0 && m_act > 0) d = 1;
         a = tick ? m_act - d : m_act;
         if (m_mode == MODE_RUN && bus.spike_valid) a = a + int'(bus.spike_weight) * 16;
         if (a > 65535) a = 65535;
         if (bus.clear) a = 0;
         if (bus.clear)                  nmode = bus.enable ? MODE_RUN : MODE_OFF;
         else if (m_mode == MODE_OFF)    nmode = bus.enable ? MODE_RUN : MODE_OFF;
         else if (bus.enable)            nmode = MODE_RUN;
         else                            nmode = (a == 0) ? MODE_OFF : MODE_DRAIN;
      end
      @(posedge clk);
      #1;
      m_act   = a;
      m_cnt   = ncnt;
      m_mode  = nmode;
      m_valid = tick;
      m_sat   = (a == 65535);
      check_val("activity", 32'(bus.activity), 32'(m_act));
      check_val("activity_valid", 32'(bus.activity_valid), 32'(m_valid));
      check_val("saturated", 32'(bus.saturated), 32'(m_sat));
      check_val("idle", 32'(bus.idle), 32'((m_mode == MODE_OFF) && (m_act == 0)));
   endtask

   task automatic spike(input logic [7:0] w);
      bus.spike_valid  = 1'b1;
      bus.spike_weight = w;
      cycle();
      bus.spike_valid  = 1'b0;
      bus.spike_weight = 8'h00;
   endtask

   task automatic pulse_reset();
      reset      = 1'b1;
      bus.enable = 1'b0;
      bus.clear  = 1'b0;
      cycle();
      reset = 1'b0;
   endtask

   // Run idle cycles until the next clock edge is a decay tick.
   task automatic wait_tick();
      for (int i = 0; i < PERIOD + 2 && m_cnt != PERIOD - 1; i++) cycle();
      if (m_cnt != PERIOD - 1) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_tick: no tick within %0d cycles", PERIOD + 2);
      end
   endtask

   initial begin
      reset            = 1'b1;
      bus.enable       = 1'b0;
      bus.clear        = 1'b0;
      bus.spike_valid  = 1'b0;
      bus.spike_weight = 8'h00;

      // Reset values, then enable and a first spike.
      cycle();
      reset = 1'b0;
      check_val("rst_activity", 32'(bus.activity), 32'h0);
      check_val("rst_idle", 32'(bus.idle), 32'h1);
      check_val("rst_valid", 32'(bus.activity_valid), 32'h0);
      check_val("rst_sat", 32'(bus.saturated), 32'h0);
      cycle();
      bus.enable = 1'b1;
      cycle();
      check_val("idle_after_enable", 32'(bus.idle), 32'h0);
      spike(8'h10);
      check_val("first_spike", 32'(bus.activity), 32'h0100);

      // Saturation with 17 back-to-back 0xFF spikes.
      pulse_reset();
      bus.enable = 1'b1;
      cycle();
      for (int i = 0; i < 16; i++) spike(8'hFF);
      check_val("sat_16", 32'(bus.activity), 32'hFF00);
      check_val("sat_16_flag", 32'(bus.saturated), 32'h0);
      spike(8'hFF);
      check_val("sat_17", 32'(bus.activity), 32'(ACT_MAX));
      check_val("sat_17_flag", 32'(bus.saturated), 32'h1);
      spike(8'hFF);
      spike(8'h01);
      check_val("sat_hold", 32'(bus.activity), 32'hFFFF);

      // Decay tick from 0x1000.
      pulse_reset();
      bus.enable = 1'b1;
      cycle();
      spike(8'h80);
      spike(8'h80);
      check_val("pre_decay", 32'(bus.activity), 32'h1000);
      wait_tick();
      cycle();
      check_val("decay_1000", 32'(bus.activity), 32'h0F00);
      check_val("decay_valid", 32'(bus.activity_valid), 32'h1);
      cycle();
      check_val("decay_valid_drop", 32'(bus.activity_valid), 32'h0);

      // Minimum decay step of one.
      pulse_reset();
      bus.enable = 1'b1;
      cycle();
      spike(8'h01);
      wait_tick();
      cycle();
      check_val("decay_10", 32'(bus.activity), 32'h000F);
      wait_tick();
      cycle();
      check_val("decay_0f", 32'(bus.activity), 32'h000E);

      // Tick and spike in the same cycle.
      pulse_reset();
      bus.enable = 1'b1;
      cycle();
      spike(8'h80);
      spike(8'h80);
      wait_tick();
      spike(8'h10);
      check_val("tick_and_spike", 32'(bus.activity), 32'h1000);
      check_val("tick_and_spike_valid", 32'(bus.activity_valid), 32'h1);

      // Drain from 0x0020 with spikes ignored, down to idle.
      pulse_reset();
      bus.enable = 1'b1;
      cycle();
      spike(8'h02);
      check_val("pre_drain", 32'(bus.activity), 32'h0020);
      bus.enable = 1'b0;
      for (int i = 0; i < 300; i++) begin
         bus.spike_valid  = $urandom_range(0, 1) == 1;
         bus.spike_weight = 8'($urandom);
         cycle();
      end
      bus.spike_valid = 1'b0;
      for (int i = 0; i < 4000 && !bus.idle; i++) cycle();
      check_val("drain_idle", 32'(bus.idle), 32'h1);
      check_val("drain_zero", 32'(bus.activity), 32'h0);

      // Re-enable mid-drain keeps the tick phase.
      pulse_reset();
      bus.enable = 1'b1;
      cycle();
      spike(8'h80);
      bus.enable = 1'b0;
      for (int i = 0; i < 100; i++) cycle();
      bus.enable = 1'b1;
      for (int i = 0; i < 2 * PERIOD; i++) cycle();

      // Clear beats a spike and a tick at 0x8000.
      pulse_reset();
      bus.enable = 1'b1;
      cycle();
      for (int i = 0; i < 16; i++) spike(8'h80);
      check_val("pre_clear", 32'(bus.activity), 32'h8000);
      wait_tick();
      bus.clear = 1'b1;
      spike(8'hFF);
      bus.clear = 1'b0;
      check_val("clear_priority", 32'(bus.activity), 32'h0);

      // Reset in the middle of a drain.
      pulse_reset();
      bus.enable = 1'b1;
      cycle();
      spike(8'hFF);
      bus.enable = 1'b0;
      for (int i = 0; i < 10; i++) cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check_val("drain_rst_activity", 32'(bus.activity), 32'h0);
      check_val("drain_rst_idle", 32'(bus.idle), 32'h1);
      check_val("drain_rst_valid", 32'(bus.activity_valid), 32'h0);
      check_val("drain_rst_sat", 32'(bus.saturated), 32'h0);

      // Random traffic: heavy spikes, then sparse ones.
      bus.enable = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 49) == 0) bus.enable = ~bus.enable;
         bus.clear        = $urandom_range(0, 199) == 0;
         reset            = $urandom_range(0, 999) == 0;
         bus.spike_valid  = (i < 2000) ? ($urandom_range(0, 2) != 0)
                                       : ($urandom_range(0, 19) == 0);
         bus.spike_weight = 8'($urandom);
         cycle();
      end
      reset           = 1'b0;
      bus.clear       = 1'b0;
      bus.spike_valid = 1'b0;
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
